// File: rtl/ai_sort_sched.sv
// Round-robin arbiter sharing one sum-sorting unit between two comparer channels.
// Grants, loads sums under FIFO backpressure, routes sorted results back, watchdog-aborts a stalled drain.
module ai_sort_sched #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  req_size0,
  input  logic [7:0]  req_size1,
  input  logic [31:0] ch_sum0,
  input  logic [31:0] ch_sum1,
  input  logic [1:0]  ch_rdy,
  output logic [1:0]  ch_stall,
  output logic [1:0]  grant,
  output logic        sort_init,
  output logic [7:0]  sort_packet_size,
  output logic [31:0] sort_sum_in,
  output logic        sort_sum_rdy,
  input  logic        sort_sum_full,
  input  logic [31:0] sort_out,
  input  logic        sort_out_rdy,
  output logic [31:0] res_data,
  output logic [1:0]  res_valid,
  output logic [1:0]  done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    r_state;
  logic [1:0]    r_grant;
  logic          r_ptr;
  logic [7:0]    r_size;
  logic [7:0]    r_in_cnt;
  logic [7:0]    r_out_cnt;
  logic [TW-1:0] r_wd;
  logic          r_sort_init;
  logic [31:0]   r_sum_in;
  logic          r_sum_rdy;
  logic [31:0]   r_res_data;
  logic [1:0]    r_res_valid;
  logic [1:0]    r_done;
  logic          r_err;

  logic       w_own;
  logic       w_pick;
  logic [7:0] w_pick_size;
  logic       w_in_done;
  logic       w_out_done;
  logic [1:0] w_stall;
  logic       w_acc;
  logic       w_route;
  logic       w_timeout;

  assign w_own       = r_grant[1];
  assign w_pick      = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_pick_size = w_pick ? req_size1 : req_size0;
  assign w_in_done   = (r_in_cnt == r_size);
  assign w_out_done  = (r_out_cnt == r_size);

  // Only the owner can be unstalled, and only while loading with room left.
  always_comb begin
    w_stall = 2'b11;
    if (r_state == S_LOAD)
      w_stall[w_own] = sort_sum_full | w_in_done;
  end

  assign w_acc     = (r_state == S_LOAD) && ch_rdy[w_own] && !w_stall[w_own];
  assign w_route   = sort_out_rdy && ((r_state == S_LOAD) || (r_state == S_DRAIN));
  assign w_timeout = (r_state == S_DRAIN) && !sort_out_rdy && (r_wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'b00;
      r_ptr       <= 1'b0;
      r_size      <= 8'd0;
      r_in_cnt    <= 8'd0;
      r_out_cnt   <= 8'd0;
      r_wd        <= '0;
      r_sort_init <= 1'b0;
      r_sum_in    <= 32'd0;
      r_sum_rdy   <= 1'b0;
      r_res_data  <= 32'd0;
      r_res_valid <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 1'b0;
    end else begin
      r_sort_init <= 1'b0;
      r_done      <= 2'b00;
      r_err       <= 1'b0;
      r_sum_rdy   <= w_acc;
      r_res_valid <= w_route ? r_grant : 2'b00;
      if (w_acc) begin
        r_sum_in <= w_own ? ch_sum1 : ch_sum0;
        r_in_cnt <= r_in_cnt + 8'd1;
      end
      if (w_route) begin
        r_res_data <= sort_out;
        r_out_cnt  <= r_out_cnt + 8'd1;
      end
      if ((r_state == S_DRAIN) && !sort_out_rdy)
        r_wd <= r_wd + TW'(1);
      else
        r_wd <= '0;

      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant   <= w_pick ? 2'b10 : 2'b01;
            r_size    <= w_pick_size;
            r_in_cnt  <= 8'd0;
            r_out_cnt <= 8'd0;
            r_state   <= (w_pick_size == 8'd0) ? S_DONE : S_INIT;
          end
        end
        S_INIT: begin
          r_sort_init <= 1'b1;
          r_state     <= S_LOAD;
        end
        S_LOAD: begin
          if (w_in_done) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_out_done) begin
            r_state <= S_DONE;
          end else if (w_timeout) begin
            // Abort: re-init doubles as a flush of the sort unit.
            r_err       <= 1'b1;
            r_sort_init <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= r_grant;
          r_grant <= 2'b00;
          r_size  <= 8'd0;
          r_ptr   <= ~w_own;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_stall         = w_stall;
  assign grant            = r_grant;
  assign sort_init        = r_sort_init;
  assign sort_packet_size = r_size;
  assign sort_sum_in      = r_sum_in;
  assign sort_sum_rdy     = r_sum_rdy;
  assign res_data         = r_res_data;
  assign res_valid        = r_res_valid;
  assign done             = r_done;
  assign err              = r_err;

endmodule

// File: tb/tb_ai_sort_sched.sv
// Scoreboard bench for ai_sort_sched: directed transactions push expected sums/results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ai_sort_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  req_size0, req_size1;
  logic [31:0] ch_sum0, ch_sum1;
  logic [1:0]  ch_rdy;
  logic [1:0]  ch_stall;
  logic [1:0]  grant;
  logic        sort_init;
  logic [7:0]  sort_packet_size;
  logic [31:0] sort_sum_in;
  logic        sort_sum_rdy;
  logic        sort_sum_full;
  logic [31:0] sort_out;
  logic        sort_out_rdy;
  logic [31:0] res_data;
  logic [1:0]  res_valid;
  logic [1:0]  done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int n_init = 0;
  int n_sumrdy = 0;
  int n_err = 0;

  logic [31:0] exp_sum[$];
  logic [33:0] exp_res[$];

  ai_sort_sched #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst(rst), .req(req), .req_size0(req_size0), .req_size1(req_size1),
    .ch_sum0(ch_sum0), .ch_sum1(ch_sum1), .ch_rdy(ch_rdy), .ch_stall(ch_stall),
    .grant(grant), .sort_init(sort_init), .sort_packet_size(sort_packet_size),
    .sort_sum_in(sort_sum_in), .sort_sum_rdy(sort_sum_rdy), .sort_sum_full(sort_sum_full),
    .sort_out(sort_out), .sort_out_rdy(sort_out_rdy), .res_data(res_data),
    .res_valid(res_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every forwarded sum and every routed result against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (sort_init) n_init++;
      if (err) n_err++;
      if (sort_sum_rdy) begin
        n_sumrdy++;
        if (exp_sum.size() == 0) chk("sum_unexpected", 64'(sort_sum_in), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("sum_fwd", 64'(sort_sum_in), 64'(exp_sum.pop_front()));
      end
      if (res_valid != 2'b00) begin
        if (exp_res.size() == 0) chk("res_unexpected", 64'({res_valid, res_data}), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("res_route", 64'({res_valid, res_data}), 64'(exp_res.pop_front()));
      end
    end
  end

  task automatic wait_grant(input logic [1:0] exp);
    int n = 0;
    tick();
    while (grant == 2'b00 && n < 10) begin tick(); n++; end
    chk("grant", 64'(grant), 64'(exp));
  endtask

  task automatic wait_done(input logic [1:0] exp);
    int n = 0;
    while (done == 2'b00 && n < 40) begin tick(); n++; end
    chk("done", 64'(done), 64'(exp));
  endtask

  // Full transaction for an already-requesting channel: n sums base*(i+1), results reversed.
  task automatic txn(input int ch, input int n, input int base);
    logic [1:0]  m;
    logic [31:0] own;
    m = (ch == 1) ? 2'b10 : 2'b01;
    wait_grant(m);
    chk("init_early", 64'(sort_init), 64'd0);
    tick();
    chk("init_pulse", 64'(sort_init), 64'd1);
    chk("psize", 64'(sort_packet_size), 64'(n));
    for (int i = 0; i < n; i++) begin
      own = 32'(base * (i + 1));
      if (ch == 1) begin ch_sum1 = own; ch_sum0 = 32'hBAD0_0000 | 32'(i); end
      else         begin ch_sum0 = own; ch_sum1 = 32'hBAD0_0000 | 32'(i); end
      ch_rdy = 2'b11;
      exp_sum.push_back(own);
      tick();
    end
    ch_rdy = 2'b00;
    for (int i = 0; i < n; i++) begin
      sort_out = 32'(base * (n - i));
      sort_out_rdy = 1'b1;
      exp_res.push_back({m, sort_out});
      tick();
    end
    sort_out_rdy = 1'b0;
    wait_done(m);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int k, base_init, base_sum, c;
    rst = 1'b1; req = 2'b00; req_size0 = 8'd0; req_size1 = 8'd0;
    ch_sum0 = 32'd0; ch_sum1 = 32'd0; ch_rdy = 2'b00;
    sort_sum_full = 1'b0; sort_out = 32'd0; sort_out_rdy = 1'b0;
    tick(); tick();
    chk("reset_outs", 64'({ch_stall, grant, sort_init, sort_sum_rdy, res_valid, done, err, sort_packet_size}),
        64'({2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'd0}));
    rst = 1'b0;
    tick();

    // Both channels request continuously: grants alternate 01,10,01.
    req = 2'b11; req_size0 = 8'd2; req_size1 = 8'd2;
    txn(0, 2, 5);
    txn(1, 2, 6);
    txn(0, 2, 7);
    req = 2'b00;

    // ch1 with the sort FIFO full for 5 cycles mid-load.
    base_sum = n_sumrdy;
    req = 2'b10; req_size1 = 8'd3;
    wait_grant(2'b10);
    tick();
    chk("init3", 64'(sort_init), 64'd1);
    k = 0;
    for (int j = 0; j < 10; j++) begin
      sort_sum_full = (j >= 1 && j <= 5);
      #1;
      chk("stall3_owner", 64'(ch_stall[1]), 64'(sort_sum_full || k == 3));
      if (!ch_stall[1] && k < 3) begin
        ch_sum1 = 32'h300 + 32'(k);
        exp_sum.push_back(ch_sum1);
        k++;
      end else begin
        ch_sum1 = 32'hFFFF_FFFF;
      end
      ch_rdy = 2'b10;
      tick();
    end
    ch_rdy = 2'b00; sort_sum_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sort_out = 32'h900 + 32'(i); sort_out_rdy = 1'b1;
      exp_res.push_back({2'b10, sort_out});
      tick();
    end
    sort_out_rdy = 1'b0;
    wait_done(2'b10);
    req = 2'b00;
    chk("sumrdy_count3", 64'(n_sumrdy - base_sum), 64'd3);

    // Plain ch0, size 4: sums 10..40, results 40..10.
    req = 2'b01; req_size0 = 8'd4;
    txn(0, 4, 10);
    req = 2'b00;
    tick();
    chk("grant_free", 64'(grant), 64'd0);

    // Size 0: no init, no sums, done two cycles after request.
    base_init = n_init; base_sum = n_sumrdy;
    req = 2'b01; req_size0 = 8'd0;
    tick();
    chk("grant_sz0", 64'(grant), 64'd1);
    chk("init_sz0", 64'(sort_init), 64'd0);
    tick();
    chk("done_sz0", 64'(done), 64'd1);
    req = 2'b00;
    tick();
    chk("init_cnt_sz0", 64'(n_init - base_init), 64'd0);
    chk("sum_cnt_sz0", 64'(n_sumrdy - base_sum), 64'd0);

    // Watchdog: size 2, only one result returned.
    req = 2'b01; req_size0 = 8'd2;
    wait_grant(2'b01);
    tick();
    chk("init_wd", 64'(sort_init), 64'd1);
    for (int i = 0; i < 2; i++) begin
      ch_sum0 = 32'h50 + 32'(i); ch_rdy = 2'b01;
      exp_sum.push_back(ch_sum0);
      tick();
    end
    ch_rdy = 2'b00;
    tick();
    sort_out = 32'h77; sort_out_rdy = 1'b1;
    exp_res.push_back({2'b01, 32'h77});
    tick();
    sort_out_rdy = 1'b0;
    c = 0;
    while (!err && c < 40) begin tick(); c++; end
    chk("err_delay", 64'(c), 64'd16);
    chk("flush_with_err", 64'(sort_init), 64'd1);
    chk("done_not_yet", 64'(done), 64'd0);
    tick();
    chk("done_after_err", 64'(done), 64'd1);
    chk("err_one_cycle", 64'(err), 64'd0);
    req = 2'b00;
    chk("err_count", 64'(n_err), 64'd1);
    req = 2'b10; req_size1 = 8'd2;
    txn(1, 2, 9);
    req = 2'b00;

    // Async reset mid-load, then a fresh ch0 transaction.
    req = 2'b01; req_size0 = 8'd4;
    wait_grant(2'b01);
    tick();
    ch_sum0 = 32'd55; ch_rdy = 2'b01;
    exp_sum.push_back(32'd55);
    tick();
    ch_rdy = 2'b00;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_stall", 64'(ch_stall), 64'd3);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_sumrdy", 64'(sort_sum_rdy), 64'd0);
    chk("rst_psize", 64'(sort_packet_size), 64'd0);
    req_size0 = 8'd2;
    tick(); tick();
    rst = 1'b0;
    txn(0, 2, 3);
    req = 2'b00;

    tick(); tick();
    chk("sum_q_empty", 64'(exp_sum.size()), 64'd0);
    chk("res_q_empty", 64'(exp_res.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ai_sort_sched.md
Name: ai_sort_sched

Overview:
Round-robin scheduler that shares one sum-sorting unit between two comparer channels. It grants the unit to one requester, pulses init with that requester's packet size, and forwards the requester's sum stream under FIFO backpressure. It then routes the sorted results back to the owning channel and releases the unit. A watchdog aborts a transaction that stalls in the drain phase.

Parameters:
TIMEOUT, 1024, max idle cycles in DRAIN with no sorted output before abort
TW, 11, watchdog counter width; TW must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  2  per-channel request level; held until done[i]
req_size0  in  8  packet size of channel 0, sampled at grant
req_size1  in  8  packet size of channel 1, sampled at grant
ch_sum0  in  32  channel 0 sum data
ch_sum1  in  32  channel 1 sum data
ch_rdy  in  2  per-channel sum strobe; honoured only when granted and not stalled
ch_stall  out  2  per-channel stall; the channel must not strobe while its bit is high
grant  out  2  one-hot owner of the sort unit (00 = free)
sort_init  out  1  init pulse to the sort unit
sort_packet_size  out  8  packet size to the sort unit, valid from sort_init until release
sort_sum_in  out  32  sum to the sort unit
sort_sum_rdy  out  1  sum strobe to the sort unit
sort_sum_full  in  1  sort unit FIFO full
sort_out  in  32  sorted sum from the sort unit
sort_out_rdy  in  1  sorted sum strobe
res_data  out  32  sorted result, registered
res_valid  out  2  one-hot result strobe to the owning channel
done  out  2  one-cycle completion pulse to the owning channel
err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs 0 except ch_stall=11. State IDLE, round-robin pointer favours channel 0, all counters 0.
- States: IDLE, INIT, LOAD, DRAIN, DONE.
- IDLE: if any req bit is set, grant the favoured channel; otherwise grant the only requester. Latch size; grant is registered. Next state is INIT. If the latched size is 0, go straight to DONE and issue no sort_init.
- INIT: sort_init=1 for exactly one cycle; sort_packet_size=latched size. Next state is LOAD. ch_stall stays high for the owner in INIT.
- LOAD:
  - ch_stall[owner] = sort_sum_full OR (in_cnt==size); the non-owner is always stalled.
  - An owner strobe while not stalled is registered and appears on sort_sum_in/sort_sum_rdy one cycle later, and in_cnt increments.
  - A strobe while stalled is ignored and not counted. Sort-unit FIFO depth must be ≥2 so the one-cycle-late full is absorbed.
  - Sorted outputs may start arriving during LOAD and are routed normally.
  - Once in_cnt==size, go to DRAIN.
- Routing:
  - Each sort_out_rdy in LOAD or DRAIN registers sort_out onto res_data and sets res_valid[owner] for one cycle, one cycle after sort_out_rdy.
  - out_cnt increments on each such strobe.
  - sort_out_rdy while in IDLE, INIT or DONE is dropped.
- DRAIN:
  - When out_cnt==size, go to DONE.
  - The watchdog resets on each sort_out_rdy and increments otherwise. When it reaches TIMEOUT: pulse err, pulse sort_init (flush), go to DONE.
- DONE: done[owner]=1 for one cycle; grant is cleared; the pointer moves to favour the other channel. Next state is IDLE.
- Next-grant timing: a new grant is possible at the earliest 1 cycle after DONE. Latency from req to sort_init is 2 cycles.
- Fairness: under continuous requests from both channels, grants alternate 0,1,0,1…
- If req drops while granted, it is ignored; the transaction completes.
- Counters are 8-bit and compare for equality against size, so no wrap occurs for size≤255.
- Async rst mid-transaction returns to the reset state immediately. The sort unit is not flushed by this block; the system rst drives it too.

Test Plan:
- Only ch0 requests, size 4, sums 10,20,30,40; sort unit returns 40,30,20,10 → sort_init one cycle 2 cycles after req; res_valid=01 four times with those values; done=01 one cycle; grant back to 00.
- req=11 held continuously, size 2 each → grant sequence 01,10,01; res_valid never strobes a non-owner; sums from the stalled channel are never forwarded.
- ch1, size 3, sort_sum_full held high 5 cycles mid-load → ch_stall[1]=1 throughout; exactly 3 sort_sum_rdy pulses total; no sum lost or duplicated.
- ch0, size 0 → no sort_init, no sort_sum_rdy; done=01 2 cycles after req.
- ch0, size 2, sort unit returns only one result, TIMEOUT=16 → err pulse 16 cycles after last sort_out_rdy, coincident with a sort_init flush pulse; done=01 next cycle; subsequent ch1 transaction completes normally.
- Assert rst mid-LOAD → outputs go to reset values immediately (ch_stall=11, grant=00); after release, a fresh ch0 request is granted to ch0.
